fetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle/pipelined core. Owns the program counter, drives the byte address into the combinational instruction_memory and captures the returned word. Buffers {pc, instr} pairs in a small FIFO toward decode with a valid/ready handshake. Accepts branch/jump redirects from execute and halts on an out-of-range PC.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic {FS_RUN, FS_HALT} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush clears both pointers and wins over push/pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, run/halt FSM and fetch buffer toward
// decode. Redirects from execute flush the buffer and reload the PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted
);

  localparam logic [31:0] PC_LIMIT = 32'(INSTR_BYTES * IMEM_WORDS);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_target;
  logic         pc_in_range, target_in_range;
  logic         fifo_full, fifo_empty;
  logic         push, pop;
  fetch_entry_t push_data, head;

  assign redirect_target = redirect_pc & ~32'h3;
  assign pc_in_range     = (pc_q < PC_LIMIT);
  assign target_in_range = (redirect_target < PC_LIMIT);

  assign pop  = !fifo_empty && out_ready;
  assign push = (state_q == FS_RUN) && pc_in_range && !redirect_valid &&
                (!fifo_full || pop);

  assign push_data.pc    = pc_q;
  assign push_data.instr = imem_instr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
      if (state_q == FS_HALT && target_in_range) begin
        state_d = FS_RUN;
      end
    end else begin
      if (state_q == FS_RUN && !pc_in_range) begin
        state_d = FS_HALT;
      end
      if (push) begin
        pc_d = pc_q + 32'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_addr = pc_q;
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven stream checks on a 256-word
// instance plus hand-written halt/reset sequences on a 4-word instance.
module tb_fetch_unit;

  typedef struct {
    logic        ready;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        expValid;
    logic        checkHead;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expAddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_pc, out_instr;
  logic        redirect_valid, out_valid, out_ready, halted;

  logic        h_rst_n = 1'b0;
  logic [31:0] h_imem_addr, h_imem_instr, h_redirect_pc, h_out_pc, h_out_instr;
  logic        h_redirect_valid, h_out_valid, h_out_ready, h_halted;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr[31:2])
      30'd0:   return 32'h0000_0000;
      30'd1:   return 32'h0020_0413;
      30'd2:   return 32'h0084_04b3;
      30'd3:   return 32'h4094_0433;
      default: return 32'hA000_0000 ^ {2'b00, addr[31:2]};
    endcase
  endfunction

  assign imem_instr   = memWord(imem_addr);
  assign h_imem_instr = memWord(h_imem_addr);

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted)
  );

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4), .FIFO_DEPTH(2)) dut_h (
    .clk            (clk),
    .rst_n          (h_rst_n),
    .imem_addr      (h_imem_addr),
    .imem_instr     (h_imem_instr),
    .redirect_valid (h_redirect_valid),
    .redirect_pc    (h_redirect_pc),
    .out_valid      (h_out_valid),
    .out_ready      (h_out_ready),
    .out_pc         (h_out_pc),
    .out_instr      (h_out_instr),
    .halted         (h_halted)
  );

  function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic ch, input logic [31:0] epc,
                              input logic [31:0] ein, input logic [31:0] ea);
    vec_t v;
    v.ready = ready; v.redirValid = rv; v.redirPc = rpc;
    v.expValid = ev; v.checkHead = ch; v.expPc = epc; v.expInstr = ein; v.expAddr = ea;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    out_ready      = v.ready;
    redirect_valid = v.redirValid;
    redirect_pc    = v.redirPc;
  endtask

  task automatic checkMain(input string tag, input logic ev, input logic ch,
                           input logic [31:0] epc, input logic [31:0] ein,
                           input logic [31:0] ea);
    checkOutput({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
    checkOutput({tag, " imem_addr"}, imem_addr, ea);
    checkOutput({tag, " halted"}, {31'b0, halted}, 32'd0);
    if (ch) begin
      checkOutput({tag, " out_pc"}, out_pc, epc);
      checkOutput({tag, " out_instr"}, out_instr, ein);
    end
  endtask

  task automatic hCheck(input string tag, input logic ev, input logic eh,
                        input logic [31:0] epc, input logic [31:0] ea);
    checkOutput({tag, " out_valid"}, {31'b0, h_out_valid}, {31'b0, ev});
    checkOutput({tag, " halted"}, {31'b0, h_halted}, {31'b0, eh});
    checkOutput({tag, " imem_addr"}, h_imem_addr, ea);
    if (ev) begin
      checkOutput({tag, " out_pc"}, h_out_pc, epc);
      checkOutput({tag, " out_instr"}, h_out_instr, memWord(epc));
    end
  endtask

  initial begin
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    h_out_ready = 1'b1; h_redirect_valid = 1'b0; h_redirect_pc = '0;

    // Rows: inputs applied after checking the state left by the previous edge.
    vecs[0]  = mk(0, 0, 0,     1, 1, 32'h00, memWord(32'h00), 32'h04);
    vecs[1]  = mk(0, 0, 0,     1, 1, 32'h00, memWord(32'h00), 32'h08);
    vecs[2]  = mk(0, 0, 0,     1, 1, 32'h00, memWord(32'h00), 32'h08);
    vecs[3]  = mk(0, 0, 0,     1, 1, 32'h00, memWord(32'h00), 32'h08);
    vecs[4]  = mk(0, 0, 0,     1, 1, 32'h00, memWord(32'h00), 32'h08);
    vecs[5]  = mk(1, 0, 0,     1, 1, 32'h00, 32'h0000_0000,   32'h08);
    vecs[6]  = mk(1, 0, 0,     1, 1, 32'h04, 32'h0020_0413,   32'h0C);
    vecs[7]  = mk(1, 0, 0,     1, 1, 32'h08, 32'h0084_04b3,   32'h10);
    vecs[8]  = mk(1, 0, 0,     1, 1, 32'h0C, 32'h4094_0433,   32'h14);
    vecs[9]  = mk(1, 0, 0,     1, 1, 32'h10, memWord(32'h10), 32'h18);
    vecs[10] = mk(0, 1, 32'h13, 1, 1, 32'h14, memWord(32'h14), 32'h1C);
    vecs[11] = mk(1, 0, 0,     0, 0, 32'h00, 32'h0,           32'h10);
    vecs[12] = mk(1, 0, 0,     1, 1, 32'h10, memWord(32'h10), 32'h14);
    vecs[13] = mk(1, 0, 0,     1, 1, 32'h14, memWord(32'h14), 32'h18);

    repeat (2) @(negedge clk);
    checkMain("reset", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkMain($sformatf("row%0d", i), vecs[i].expValid, vecs[i].checkHead,
                vecs[i].expPc, vecs[i].expInstr, vecs[i].expAddr);
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset asserted between edges must clear state at once.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkMain("async_rst", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkMain("restart0", 1'b1, 1'b1, 32'h00, 32'h0000_0000, 32'h04);
    @(negedge clk);
    checkMain("restart1", 1'b1, 1'b1, 32'h04, 32'h0020_0413, 32'h08);

    // Halt sequence on the 4-word instance.
    @(negedge clk);
    h_rst_n = 1'b1;
    @(negedge clk); hCheck("h1", 1, 0, 32'h00, 32'h04);
    @(negedge clk); hCheck("h2", 1, 0, 32'h04, 32'h08);
    @(negedge clk); hCheck("h3", 1, 0, 32'h08, 32'h0C);
    @(negedge clk); hCheck("h4", 1, 0, 32'h0C, 32'h10);
    @(negedge clk); hCheck("h5", 0, 1, 32'h00, 32'h10);
    @(negedge clk); hCheck("h6", 0, 1, 32'h00, 32'h10);
    h_redirect_valid = 1'b1; h_redirect_pc = 32'h22;
    @(negedge clk); hCheck("h_oor", 0, 1, 32'h00, 32'h20);
    h_redirect_pc = 32'h04;
    @(negedge clk); hCheck("h_redir", 0, 0, 32'h00, 32'h04);
    h_redirect_valid = 1'b0;
    @(negedge clk); hCheck("h_resume", 1, 0, 32'h04, 32'h08);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
